// File: rtl/gray_seq_arbiter.sv
// Round-robin arbiter in front of a shared Gray-code burst generator.
// Each granted requester receives LEN beats of gray(0..LEN-1) with valid/last and a done pulse.
module gray_seq_arbiter #(
  parameter int CBITS = 16,
  parameter int NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*CBITS-1:0]   len_in,
  input  logic                    pause,
  output logic [NREQ-1:0]         grant,
  output logic [CBITS-1:0]        gray_out,
  output logic                    gray_vld,
  output logic                    gray_last,
  output logic [NREQ-1:0]         done,
  output logic                    busy
);

  localparam int PW = $clog2(NREQ);
  localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

  typedef enum logic {IDLE, RUN} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [CBITS-1:0]  cnt_q, cnt_d;
  logic [CBITS-1:0]  len_q, len_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [CBITS-1:0]  gray_q, gray_d;
  logic              vld_q, vld_d;
  logic              last_q, last_d;
  logic [NREQ-1:0]   done_q, done_d;

  logic [CBITS-1:0]  len_arr [NREQ];
  logic              found;
  logic [PW-1:0]     win;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    if (int'(i) == NREQ - 1) return '0;
    return i + PW'(1);
  endfunction

  for (genvar g = 0; g < NREQ; g++) begin : g_len
    assign len_arr[g] = len_in[g*CBITS +: CBITS];
  end

  // Round-robin search: first set req bit at or after ptr, wrapping modulo NREQ.
  always_comb begin
    logic [PW:0] sum;
    found = 1'b0;
    win   = ptr_q;
    sum   = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(i);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      if (!found && req[sum[PW-1:0]]) begin
        found = 1'b1;
        win   = sum[PW-1:0];
      end
    end
  end

  // NOTE: every signal gets its hold/default value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    grant_d = grant_q;
    gray_d  = gray_q;
    vld_d   = 1'b0;
    last_d  = 1'b0;
    done_d  = '0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          if (len_arr[win] != '0) begin
            grant_d      = '0;
            grant_d[win] = 1'b1;
            len_d        = len_arr[win];
            cnt_d        = '0;
            owner_d      = win;
            state_d      = RUN;
          end else begin
            // Zero-length request is acknowledged without a grant or any beats.
            done_d[win] = 1'b1;
            ptr_d       = next_idx(win);
          end
        end
      end
      RUN: begin
        if (!pause) begin
          gray_d = cnt_q ^ (cnt_q >> 1);
          vld_d  = 1'b1;
          cnt_d  = cnt_q + CBITS'(1);
          if (cnt_q == len_q - CBITS'(1)) begin
            last_d          = 1'b1;
            done_d[owner_q] = 1'b1;
            grant_d         = '0;
            ptr_d           = next_idx(owner_q);
            state_d         = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: all registers, including the datapath, are reset so a mid-burst reset leaves no stale outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      grant_q <= '0;
      gray_q  <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      grant_q <= grant_d;
      gray_q  <= gray_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign grant     = grant_q;
  assign gray_out  = gray_q;
  assign gray_vld  = vld_q;
  assign gray_last = last_q;
  assign done      = done_q;
  assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_gray_seq_arbiter.sv
// Self-checking bench for gray_seq_arbiter: cycle vector tables, directed corner sequences,
// and randomized rounds scored against a transaction-level round-robin/Gray model.
module tb_gray_seq_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] len_in;
  logic        pause;
  logic [3:0]  grant;
  logic [15:0] gray_out;
  logic        gray_vld, gray_last;
  logic [3:0]  done;
  logic        busy;

  logic [1:0]  req4;
  logic [7:0]  len4;
  logic        pause4;
  logic [1:0]  grant4;
  logic [3:0]  gray4;
  logic        vld4, last4;
  logic [1:0]  done4;
  logic        busy4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  gray_seq_arbiter #(.CBITS(16), .NREQ(4)) u_dut (
    .clk(clk), .rst(rst), .req(req), .len_in(len_in), .pause(pause),
    .grant(grant), .gray_out(gray_out), .gray_vld(gray_vld), .gray_last(gray_last),
    .done(done), .busy(busy)
  );

  gray_seq_arbiter #(.CBITS(4), .NREQ(2)) u_dut4 (
    .clk(clk), .rst(rst), .req(req4), .len_in(len4), .pause(pause4),
    .grant(grant4), .gray_out(gray4), .gray_vld(vld4), .gray_last(last4),
    .done(done4), .busy(busy4)
  );

  typedef struct {
    logic [3:0]  req;
    logic [63:0] len;
    logic        pause;
    logic [3:0]  grant;
    logic [15:0] gray;
    logic        vld;
    logic        last;
    logic [3:0]  done;
    logic        busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] r, input logic [63:0] l, input logic p,
                              input logic [3:0] g, input logic [15:0] gy, input logic v,
                              input logic la, input logic [3:0] d, input logic b);
    vec_t x;
    x.req = r; x.len = l; x.pause = p; x.grant = g; x.gray = gy;
    x.vld = v; x.last = la; x.done = d; x.busy = b;
    return x;
  endfunction

  function automatic logic [3:0] oh(input int i);
    return 4'b0001 << i;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; pause = 1'b0; len_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic apply_rows(input int lo, input int hi);
    for (int k = lo; k < hi; k++) begin
      req = tbl[k].req; len_in = tbl[k].len; pause = tbl[k].pause;
      check($sformatf("row%0d grant", k), grant,     tbl[k].grant);
      check($sformatf("row%0d gray",  k), gray_out,  tbl[k].gray);
      check($sformatf("row%0d vld",   k), gray_vld,  tbl[k].vld);
      check($sformatf("row%0d last",  k), gray_last, tbl[k].last);
      check($sformatf("row%0d done",  k), done,      tbl[k].done);
      check($sformatf("row%0d busy",  k), busy,      tbl[k].busy);
      @(negedge clk);
    end
  endtask

  // Holds req=mask constant and scores nserv services against the round-robin order from ptr 0.
  task automatic run_round(input logic [3:0] mask, input logic [63:0] lens, input int pause_pct,
                           input int nserv, input bit rst_first);
    int exp_id[$];
    int exp_len[$];
    int p, s, b, cyc, id, ln;
    logic [3:0] prev_grant;
    logic       prev_pause;
    if (rst_first) do_reset();
    p = 0;
    for (int n = 0; n < nserv; n++) begin
      for (int i = 0; i < 4; i++) begin
        int idx;
        idx = (p + i) % 4;
        if (mask[idx]) begin
          exp_id.push_back(idx);
          exp_len.push_back(int'(lens[idx*16 +: 16]));
          p = (idx + 1) % 4;
          break;
        end
      end
    end
    req = mask; len_in = lens; pause = 1'b0;
    s = 0; b = 0; cyc = 0; prev_grant = '0; prev_pause = 1'b0;
    while (s < nserv && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      id = exp_id[s]; ln = exp_len[s];
      if (prev_grant != '0) check("rr beat vs pause", gray_vld, !prev_pause);
      if (grant != '0) check("rr grant owner", grant, oh(id));
      if (gray_vld) begin
        check("rr beat on nonzero burst", ln != 0, 1);
        check("rr gray value", gray_out, 64'(b ^ (b >> 1)));
        check("rr last flag", gray_last, b == ln - 1);
        check("rr done on beat", done, (b == ln - 1) ? oh(id) : 4'b0000);
        b++;
        if (gray_last) begin s++; b = 0; end
      end else if (done != '0) begin
        check("rr zero-len done", done, oh(id));
        check("rr zero-len expected", ln, 0);
        s++;
      end else if (gray_last) begin
        check("rr stray last", gray_last, 0);
      end
      prev_grant = grant;
      pause = ($urandom_range(99) < pause_pct);
      prev_pause = pause;
    end
    check("rr services completed", s, nserv);
    pause = 1'b0;
  endtask

  initial begin
    int beats;
    int got[$];
    int g4[15];
    bit saw_last;
    rst = 1'b1; req = '0; len_in = '0; pause = 1'b0;
    req4 = '0; len4 = '0; pause4 = 1'b0;

    // Single burst len0=3 (rows 0-5)
    tbl.push_back(mk(4'h1, 64'h3, 0, 4'h0, 16'h0, 0, 0, 4'h0, 0));
    tbl.push_back(mk(4'h0, 64'h3, 0, 4'h1, 16'h0, 0, 0, 4'h0, 1));
    tbl.push_back(mk(4'h0, 64'h3, 0, 4'h1, 16'h0, 1, 0, 4'h0, 1));
    tbl.push_back(mk(4'h0, 64'h3, 0, 4'h1, 16'h1, 1, 0, 4'h0, 1));
    tbl.push_back(mk(4'h0, 64'h3, 0, 4'h0, 16'h3, 1, 1, 4'h1, 0));
    tbl.push_back(mk(4'h0, 64'h3, 0, 4'h0, 16'h3, 0, 0, 4'h0, 0));
    // len0=0, len1=1 (rows 6-10)
    tbl.push_back(mk(4'h3, 64'h1_0000, 0, 4'h0, 16'h0, 0, 0, 4'h0, 0));
    tbl.push_back(mk(4'h3, 64'h1_0000, 0, 4'h0, 16'h0, 0, 0, 4'h1, 0));
    tbl.push_back(mk(4'h0, 64'h1_0000, 0, 4'h2, 16'h0, 0, 0, 4'h0, 1));
    tbl.push_back(mk(4'h0, 64'h1_0000, 0, 4'h0, 16'h0, 1, 1, 4'h2, 0));
    tbl.push_back(mk(4'h0, 64'h1_0000, 0, 4'h0, 16'h0, 0, 0, 4'h0, 0));
    // len0=6 with a 3-cycle pause after the second beat (rows 11-22)
    tbl.push_back(mk(4'h1, 64'h6, 0, 4'h0, 16'h0, 0, 0, 4'h0, 0));
    tbl.push_back(mk(4'h0, 64'h6, 0, 4'h1, 16'h0, 0, 0, 4'h0, 1));
    tbl.push_back(mk(4'h0, 64'h6, 0, 4'h1, 16'h0, 1, 0, 4'h0, 1));
    tbl.push_back(mk(4'h0, 64'h6, 1, 4'h1, 16'h1, 1, 0, 4'h0, 1));
    tbl.push_back(mk(4'h0, 64'h6, 1, 4'h1, 16'h1, 0, 0, 4'h0, 1));
    tbl.push_back(mk(4'h0, 64'h6, 1, 4'h1, 16'h1, 0, 0, 4'h0, 1));
    tbl.push_back(mk(4'h0, 64'h6, 0, 4'h1, 16'h1, 0, 0, 4'h0, 1));
    tbl.push_back(mk(4'h0, 64'h6, 0, 4'h1, 16'h3, 1, 0, 4'h0, 1));
    tbl.push_back(mk(4'h0, 64'h6, 0, 4'h1, 16'h2, 1, 0, 4'h0, 1));
    tbl.push_back(mk(4'h0, 64'h6, 0, 4'h1, 16'h6, 1, 0, 4'h0, 1));
    tbl.push_back(mk(4'h0, 64'h6, 0, 4'h0, 16'h7, 1, 1, 4'h1, 0));
    tbl.push_back(mk(4'h0, 64'h6, 0, 4'h0, 16'h7, 0, 0, 4'h0, 0));

    do_reset(); apply_rows(0, 6);
    do_reset(); apply_rows(6, 11);
    do_reset(); apply_rows(11, 23);

    // All four requesting with len 2: order 0,1,2,3,0
    run_round(4'hF, {16'd2, 16'd2, 16'd2, 16'd2}, 0, 5, 1'b1);

    // Move ptr to 2, start a burst on requester 2, then reset mid-burst
    do_reset();
    req = 4'b0010; len_in = {16'd0, 16'd5, 16'd1, 16'd0};
    @(negedge clk); req = '0;
    repeat (3) @(negedge clk);
    req = 4'b0100;
    @(negedge clk); req = '0;
    beats = 0;
    for (int c = 0; c < 20 && beats < 2; c++) begin
      @(negedge clk);
      if (gray_vld) beats++;
    end
    check("mid beats before reset", beats, 2);
    #2 rst = 1'b1;
    #1;
    check("mid rst grant", grant, 0);
    check("mid rst gray", gray_out, 0);
    check("mid rst vld", gray_vld, 0);
    check("mid rst last", gray_last, 0);
    check("mid rst done", done, 0);
    check("mid rst busy", busy, 0);
    @(negedge clk); rst = 1'b0;
    run_round(4'b1010, {16'd3, 16'd0, 16'd2, 16'd0}, 0, 2, 1'b0);

    // 4-bit counter, full 15-beat burst
    g4 = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9};
    @(negedge clk); req4 = 2'b01; len4 = 8'h0F;
    @(negedge clk); req4 = 2'b00;
    saw_last = 1'b0;
    for (int c = 0; c < 40 && !saw_last; c++) begin
      @(negedge clk);
      if (vld4) begin
        got.push_back(int'(gray4));
        if (last4) begin
          saw_last = 1'b1;
          check("g4 done on last", done4, 2'b01);
        end
      end
    end
    check("g4 last seen", saw_last, 1);
    check("g4 beat count", got.size(), 15);
    for (int i = 0; i < got.size() && i < 15; i++)
      check($sformatf("g4 beat%0d", i), got[i], g4[i]);
    for (int i = 1; i < got.size(); i++)
      check($sformatf("g4 hamming%0d", i), $countones(got[i] ^ got[i-1]), 1);

    // Randomized rounds
    for (int r = 0; r < 25; r++) begin
      logic [3:0]  m;
      logic [63:0] l;
      m = 4'($urandom_range(1, 15));
      l = '0;
      for (int i = 0; i < 4; i++)
        l[i*16 +: 16] = ($urandom_range(3) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
      run_round(m, l, $urandom_range(0, 40), 2 * $countones(m) + 1, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
